// File: rtl/dma_eastbridge_if.sv
// dma_eastbridge_if
// Bundles every device-side and memory-side DMA signal of the eastbridge arbiter.
//   cpu_hold       : CPU owns memory this cycle
//   dev_want       : per-device DMA request
//   dev_addr       : per-device address, device i in [16i+15:16i]
//   dev_out        : per-device write data, same packing as dev_addr
//   dev_wren       : per-device write enable
//   dev_access     : registered one-hot grant
//   dev_data       : read data broadcast to all devices
//   dev_data_valid : one-hot read-data-valid
//   mem_addr/mem_wdata/mem_wren/mem_rden : memory DMA port outputs
//   mem_rdata      : memory read data (one-cycle synchronous latency)
// Modports: slave = arbiter view, master = device/memory-side view.
interface dma_eastbridge_if #(
  parameter int NUM_DEV = 4
);
  logic                   cpu_hold;
  logic [NUM_DEV-1:0]     dev_want;
  logic [16*NUM_DEV-1:0]  dev_addr;
  logic [16*NUM_DEV-1:0]  dev_out;
  logic [NUM_DEV-1:0]     dev_wren;
  logic [NUM_DEV-1:0]     dev_access;
  logic [15:0]            dev_data;
  logic [NUM_DEV-1:0]     dev_data_valid;
  logic [15:0]            mem_addr;
  logic [15:0]            mem_wdata;
  logic                   mem_wren;
  logic                   mem_rden;
  logic [15:0]            mem_rdata;

  modport slave (
    input  cpu_hold, dev_want, dev_addr, dev_out, dev_wren, mem_rdata,
    output dev_access, dev_data, dev_data_valid,
           mem_addr, mem_wdata, mem_wren, mem_rden
  );

  modport master (
    output cpu_hold, dev_want, dev_addr, dev_out, dev_wren, mem_rdata,
    input  dev_access, dev_data, dev_data_valid,
           mem_addr, mem_wdata, mem_wren, mem_rden
  );
endinterface

// File: rtl/dma_eastbridge.sv
// dma_eastbridge
// Round-robin DMA arbiter between NUM_DEV peripheral DMA ports and the single
// DMA port of main memory. One device is granted per cycle through a registered
// one-hot dev_access; during that cycle its address/data/write-enable are muxed
// onto the memory port, and read data is steered back one cycle later with a
// one-hot dev_data_valid. No new grant is issued while cpu_hold is high.
// Ports:
//   DMA_CLOCK   : sole clock, rising edge
//   DMA_RESET_n : asynchronous active-low reset
//   bus         : dma_eastbridge_if.slave carrying all device and memory signals
// Optional feature: define DMA_BURST_EN to let the granted device keep the
// grant for up to MAX_BURST consecutive cycles while it still wants.
module dma_eastbridge #(
  parameter int NUM_DEV   = 4,
  parameter int MAX_BURST = 4
) (
  input logic             DMA_CLOCK,
  input logic             DMA_RESET_n,
  dma_eastbridge_if.slave bus
);

  localparam int PTR_W = (NUM_DEV > 1) ? $clog2(NUM_DEV) : 1;

  if (NUM_DEV < 2 || NUM_DEV > 8 || MAX_BURST < 1 || MAX_BURST > 15) begin : g_bad_param
    $error("dma_eastbridge: NUM_DEV or MAX_BURST out of range");
  end

  logic [PTR_W-1:0]   ptr;
  logic [PTR_W-1:0]   grant_idx;
  logic [PTR_W-1:0]   rr_idx;
  logic [PTR_W-1:0]   next_idx;
  logic               rr_found;
  logic               next_grant;
  logic               ptr_adv;
  logic [NUM_DEV-1:0] access_q;
  logic [NUM_DEV-1:0] valid_q;
  int                 rr_cand;

  // First requesting device at or after ptr, wrapping modulo NUM_DEV.
  always_comb begin
    rr_found = 1'b0;
    rr_idx   = '0;
    rr_cand  = 0;
    for (int k = 0; k < NUM_DEV; k++) begin
      rr_cand = (int'(ptr) + k) % NUM_DEV;
      if (!rr_found && bus.dev_want[PTR_W'(rr_cand)]) begin
        rr_found = 1'b1;
        rr_idx   = PTR_W'(rr_cand);
      end
    end
  end

`ifdef DMA_BURST_EN
  logic [3:0] burst_cnt;
  logic [3:0] burst_cnt_d;
  logic       keep_grant;

  // Keep the current owner while it still wants and its burst is not used up;
  // otherwise fall back to round-robin, which starts just after the owner.
  always_comb begin
    keep_grant  = (|access_q) && !bus.cpu_hold && bus.dev_want[grant_idx] &&
                  (burst_cnt < 4'(MAX_BURST));
    next_grant  = !bus.cpu_hold && (keep_grant || rr_found);
    next_idx    = keep_grant ? grant_idx : rr_idx;
    ptr_adv     = next_grant && !keep_grant;
    burst_cnt_d = 4'd0;
    if (next_grant) begin
      burst_cnt_d = keep_grant ? burst_cnt + 4'd1 : 4'd1;
    end
  end

  // Burst length of the current owner; zero when idle or held off by the CPU.
  always_ff @(posedge DMA_CLOCK or negedge DMA_RESET_n) begin
    if (!DMA_RESET_n) begin
      burst_cnt <= 4'd0;
    end else begin
      burst_cnt <= burst_cnt_d;
    end
  end
`else
  // Plain per-cycle round-robin.
  always_comb begin
    next_grant = !bus.cpu_hold && rr_found;
    next_idx   = rr_idx;
    ptr_adv    = next_grant;
  end
`endif

  // Grant, pointer and read-valid registers. The valid is taken from the grant
  // of the cycle just ending, so it lines up with the memory's read latency.
  always_ff @(posedge DMA_CLOCK or negedge DMA_RESET_n) begin
    if (!DMA_RESET_n) begin
      access_q  <= '0;
      valid_q   <= '0;
      grant_idx <= '0;
      ptr       <= '0;
    end else begin
      valid_q <= access_q & ~bus.dev_wren;
      if (next_grant) begin
        access_q  <= NUM_DEV'(1) << next_idx;
        grant_idx <= next_idx;
      end else begin
        access_q  <= '0;
      end
      if (ptr_adv) begin
        ptr <= (next_idx == PTR_W'(NUM_DEV - 1)) ? '0 : next_idx + 1'b1;
      end
    end
  end

  // Memory port follows the registered grant; quiet when nobody is granted.
  always_comb begin
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    bus.mem_wren  = 1'b0;
    bus.mem_rden  = 1'b0;
    if (|access_q) begin
      bus.mem_addr  = bus.dev_addr[16*int'(grant_idx) +: 16];
      bus.mem_wdata = bus.dev_out[16*int'(grant_idx) +: 16];
      bus.mem_wren  = bus.dev_wren[grant_idx];
      bus.mem_rden  = ~bus.dev_wren[grant_idx];
    end
  end

  assign bus.dev_access     = access_q;
  assign bus.dev_data_valid = valid_q;
  assign bus.dev_data       = (|valid_q) ? bus.mem_rdata : 16'h0000;

endmodule

// File: doc/dma_eastbridge.md
Name: dma_eastbridge

Overview:
- Eastbridge DMA arbiter between all peripheral device DMA ports and the single DMA port of main memory.
- Collects per-device DMA_want requests and grants exactly one device per cycle via its DMA_access input, round-robin.
- Muxes the granted device's address, write data and write enable onto the memory port, and steers read data back to the granted device.
- Yields to the CPU whenever cpu_hold is asserted.

Parameters:
- NUM_DEV, 4: number of attached devices, range 2..8.
- MAX_BURST, 4: max consecutive grants to one device, used only with DMA_BURST_EN; range 1..15.

Ports:
- DMA_CLOCK  in  1  sole clock, all state on rising edge.
- DMA_RESET_n  in  1  asynchronous, active-low reset.
- cpu_hold  in  1  CPU owns memory this cycle; no new grant issued at this edge.
- dev_want  in  NUM_DEV  per-device DMA_want.
- dev_addr  in  16*NUM_DEV  per-device DMA_addr; device i in bits [16i+15:16i].
- dev_out  in  16*NUM_DEV  per-device DMA_out (write data), same packing.
- dev_wren  in  NUM_DEV  per-device DMA_wren.
- dev_access  out  NUM_DEV  per-device DMA_access, one-hot or zero, registered.
- dev_data  out  16  read data broadcast to all devices (DMA_data).
- dev_data_valid  out  NUM_DEV  one-hot: dev_data is valid for device i this cycle.
- mem_addr  out  16  memory DMA address.
- mem_wdata  out  16  memory write data.
- mem_wren  out  1  memory write strobe.
- mem_rden  out  1  memory read strobe.
- mem_rdata  in  16  memory read data, 1-cycle synchronous latency.

Behaviour:
- Reset (async, DMA_RESET_n=0): dev_access=0, dev_data_valid=0, rr pointer=0, burst count=0. mem_addr/mem_wdata=0, mem_wren=0, mem_rden=0, dev_data=0.
- Grant, edge k:
  - if cpu_hold=1 or dev_want=0, dev_access<=0.
  - else dev_access<=one-hot of first i with dev_want[i]=1, searching ptr, ptr+1, ... modulo NUM_DEV.
  - after granting i, ptr<=(i+1) mod NUM_DEV; ptr unchanged when no grant.
- Access cycle (dev_access[i]=1, between edges k and k+1), combinational from the registered grant:
  - mem_addr=dev_addr[i], mem_wdata=dev_out[i], mem_wren=dev_wren[i], mem_rden=~dev_wren[i].
  - no grant: all mem outputs 0.
  - the device must hold addr/out/wren stable through the access cycle; it may drop want in the same cycle.
- Read return:
  - dev_data_valid<=dev_access & ~{dev_wren} at edge k+1, so valid is asserted the cycle after access.
  - dev_data=mem_rdata while any valid bit is set, else 0.
  - read latency from access cycle: exactly 1 cycle.
  - writes complete in the access cycle; no valid is issued for a write.
- Single requester: may be granted every cycle back-to-back; reads pipeline at 1 access per cycle.
- cpu_hold asserted mid-stream:
  - the access already granted completes, and its read valid still appears next cycle.
  - no further grant until cpu_hold=0.
- Requests arriving during a grant are arbitrated at the next edge; dev_want is never latched.
- dev_access and dev_data_valid are never multi-hot.
- Reset mid-read drops the pending valid.

Optional Feature:
- Macro: DMA_BURST_EN.
- Defined:
  - the granted device i keeps dev_access while dev_want[i]=1 and cpu_hold=0, up to MAX_BURST consecutive cycles.
  - a 4-bit burst counter counts consecutive grants to i.
  - on reaching MAX_BURST, the next grant goes by round-robin from i+1; i is regranted only if no other device wants.
  - the counter clears on rotation, on an idle cycle, on cpu_hold, and on reset.
  - ptr advances only when the grant moves.
- Undefined: pure per-cycle round-robin as above; no counter logic.

Test Plan:
- Reset, then dev_want=0000 for 5 cycles -> dev_access=0000, mem_wren=0, mem_rden=0, dev_data_valid=0000.
- dev1 wants, wren=1, addr=0x1234, out=0xBEEF -> dev_access=0010 one cycle after want. In that cycle mem_addr=0x1234, mem_wdata=0xBEEF, mem_wren=1. No valid pulse follows.
- dev2 read at addr 0x0040, memory returns 0x5A5A -> dev_access=0100, mem_rden=1 in cycle t. Next cycle dev_data_valid=0100 and dev_data=0x5A5A.
- All four want continuously, burst feature off -> grant order 0001,0010,0100,1000,0001... with no gaps; each read's valid lags its access by 1 cycle.
- All want, cpu_hold high for cycles 3-5 -> dev_access=0000 in the cycles after those edges. Rotation resumes at the device after the last granted one; the read granted before hold still gets its valid.
- DMA_BURST_EN, MAX_BURST=4, dev0 and dev3 want continuously -> dev0 granted 4 cycles, then dev3 for 4, alternating. Assert reset mid-burst -> dev_access=0000 immediately, and the next grant goes to dev0.
